// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter: two CPU masters (fetch, load/store) onto one slave port.
// Grants whole cyc-to-cyc bus cycles, replays strobes raised while waiting, and aborts silent slaves.
module wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_sel,
  output logic            m0_ack,
  output logic            m0_err,

  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_sel,
  output logic            m1_ack,
  output logic            m1_err,

  output logic [DW-1:0]   m_rdata,

  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_sel,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_ack,
  input  logic            s_err,

  output logic            o_owner,
  output logic            o_busy
);

  localparam int TW = (TIMEOUT <= 255) ? 8 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TCNT_MAX = '1;
  localparam logic [TW-1:0] TCNT_LIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            owner, last;
  logic            pend0, pend1;
  logic            pend0_next, pend1_next;
  logic            wait_ack, wait_ack_next;
  logic [TW-1:0]   tcnt, tcnt_next;

  logic            sel;
  logic            act;
  logic            a_cyc, a_stb, a_we, a_pend;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_wdata;
  logic [DW/8-1:0] a_sel;
  logic            bus_cyc, bus_stb;
  logic            fwd, issue, timeout_hit;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last,
  // and with no requester the previous owner stays selected.
  always_comb begin
    sel = owner;
    if (m0_cyc && !m1_cyc)
      sel = 1'b0;
    else if (m1_cyc && !m0_cyc)
      sel = 1'b1;
    else if (m0_cyc && m1_cyc)
      sel = ~last;
  end

  // In IDLE the combinational pick drives the slave so a grant costs no cycle.
  assign act     = (state == IDLE) ? sel : owner;
  assign a_cyc   = act ? m1_cyc   : m0_cyc;
  assign a_stb   = act ? m1_stb   : m0_stb;
  assign a_we    = act ? m1_we    : m0_we;
  assign a_addr  = act ? m1_addr  : m0_addr;
  assign a_wdata = act ? m1_wdata : m0_wdata;
  assign a_sel   = act ? m1_sel   : m0_sel;
  assign a_pend  = act ? pend1    : pend0;

  always_comb begin
    bus_cyc = 1'b0;
    bus_stb = 1'b0;
    unique case (state)
      IDLE, BUSY: begin
        bus_cyc = a_cyc;
        bus_stb = a_cyc & (a_stb | a_pend);
      end
      default: begin
        bus_cyc = 1'b0;
        bus_stb = 1'b0;
      end
    endcase
  end

  assign s_cyc   = reset & bus_cyc;
  assign s_stb   = reset & bus_stb;
  assign s_we    = a_we;
  assign s_addr  = a_addr;
  assign s_wdata = a_wdata;
  assign s_sel   = a_sel;
  assign m_rdata = s_rdata;

  // A strobe counts as newly issued only when nothing is already awaiting a response,
  // so a master that holds stb until ack still runs into the timeout.
  assign fwd   = s_cyc & s_stb;
  assign issue = fwd & ~wait_ack;

  assign timeout_hit = (TIMEOUT != 0) && (state == BUSY) && a_cyc && wait_ack &&
                       !s_ack && !s_err && (tcnt == TCNT_LIM);

  assign m0_ack = s_ack & s_cyc & ~act;
  assign m1_ack = s_ack & s_cyc &  act;
  assign m0_err = reset & ((s_err & s_cyc) | timeout_hit) & ~act;
  assign m1_err = reset & ((s_err & s_cyc) | timeout_hit) &  act;

  assign o_owner = act;
  assign o_busy  = (state != IDLE);

  // Next-state logic: leaving BUSY or DRAIN always waits for the owner to drop cyc.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (a_cyc) state_next = BUSY;
      BUSY: begin
        if (!a_cyc)
          state_next = IDLE;
        else if (timeout_hit)
          state_next = DRAIN;
      end
      DRAIN:   if (!a_cyc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A strobe from the master not currently driving the slave is remembered until that
  // master is granted and the strobe reaches the slave, or until it abandons its cycle.
  always_comb begin
    pend0_next = m0_cyc && !(fwd && !act) && (pend0 || (m0_stb && act));
    pend1_next = m1_cyc && !(fwd &&  act) && (pend1 || (m1_stb && !act));
  end

  always_comb begin
    wait_ack_next = (state != DRAIN) && a_cyc && !s_ack && !s_err && !timeout_hit &&
                    (wait_ack || fwd);
    tcnt_next = tcnt;
    if ((state != BUSY) || s_ack || s_err || issue)
      tcnt_next = '0;
    else if (wait_ack && (tcnt != TCNT_MAX))
      tcnt_next = tcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      wait_ack <= 1'b0;
      tcnt     <= '0;
    end else begin
      state    <= state_next;
      pend0    <= pend0_next;
      pend1    <= pend1_next;
      wait_ack <= wait_ack_next;
      tcnt     <= tcnt_next;
      if ((state == IDLE) && a_cyc) begin
        owner <= sel;
        last  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized rounds, responses checked by a
// scoreboard monitor against a round-robin reference model.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err;
  logic [31:0] m_rdata;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;
  logic        o_owner, o_busy;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_last;

  bit          slave_fixed;
  int          slave_lat;
  bit          slave_data_en;
  logic [31:0] slave_data;
  int          slave_cur_lat;
  logic [31:0] slave_cur_data;

  wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
    .m_rdata(m_rdata),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_sel(s_sel), .s_rdata(s_rdata), .s_ack(s_ack), .s_err(s_err),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The slave answers with a word derived from what it saw, so the data also proves the request mux.
  function automatic logic [31:0] model_data(input logic [31:0] addr, input logic we,
                                             input logic [31:0] wdata, input logic [3:0] sel);
    return addr ^ (we ? wdata : 32'h0) ^ {sel, 28'h0};
  endfunction

  task automatic push_exp(input int id, input logic err, input logic [31:0] data);
    exp_t e;
    e.id = id; e.err = err; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive_master(input int id, input logic cyc, input logic stb, input logic [31:0] addr,
                              input logic we, input logic [31:0] wdata, input logic [3:0] sel);
    if (id == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_addr = addr; m0_we = we; m0_wdata = wdata; m0_sel = sel;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_addr = addr; m1_we = we; m1_wdata = wdata; m1_sel = sel;
    end
  endtask

  // One master transaction: raise cyc with a single-cycle strobe, wait for ack/err, hold, release.
  task automatic master_txn(input int id, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic [3:0] sel, input int hold);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    drive_master(id, 1'b1, 1'b1, addr, we, wdata, sel);
    @(posedge clk); #1;
    drive_master(id, 1'b1, 1'b0, addr, we, wdata, sel);
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = (id == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL master%0d_response: got no ack/err, expected one within 60 cycles", id);
    end
    repeat (hold) @(posedge clk);
    #1;
    drive_master(id, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
  endtask

  // One arbitration round: the model orders the grants by round-robin before the masters start.
  task automatic apply_stimulus(input bit r0, input bit r1, input int hold0, input int hold1);
    logic [31:0] a0, a1, w0, w1, d0, d1;
    logic        we0, we1;
    logic [3:0]  s0, s1;
    a0 = $urandom & 32'hFFFF_FFFC; a1 = $urandom & 32'hFFFF_FFFC;
    w0 = $urandom; w1 = $urandom;
    we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
    s0 = 4'($urandom); s1 = 4'($urandom);
    d0 = model_data(a0, we0, w0, s0);
    d1 = model_data(a1, we1, w1, s1);
    if (r0 && r1) begin
      if (model_last) begin
        push_exp(0, 1'b0, d0); push_exp(1, 1'b0, d1); model_last = 1'b1;
      end else begin
        push_exp(1, 1'b0, d1); push_exp(0, 1'b0, d0); model_last = 1'b0;
      end
    end else if (r0) begin
      push_exp(0, 1'b0, d0); model_last = 1'b0;
    end else if (r1) begin
      push_exp(1, 1'b0, d1); model_last = 1'b1;
    end
    fork
      begin if (r0) master_txn(0, a0, we0, w0, s0, hold0); end
      begin if (r1) master_txn(1, a1, we1, w1, s1, hold1); end
    join
  endtask

  // Slave: sees a strobe, answers after a latency of whole cycles.
  initial begin
    s_ack = 1'b0; s_err = 1'b0; s_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (s_cyc && s_stb) begin
        slave_cur_lat  = slave_fixed ? slave_lat : int'($urandom_range(1, 3));
        slave_cur_data = slave_data_en ? slave_data : model_data(s_addr, s_we, s_wdata, s_sel);
        repeat (slave_cur_lat) @(posedge clk);
        #1;
        s_ack = 1'b1; s_rdata = slave_cur_data;
        @(posedge clk); #1;
        s_ack = 1'b0;
      end
    end
  end

  logic mon_hit, mon_err;
  exp_t mon_e;

  // Scoreboard monitor: every response a master sees must be the next one the model expects.
  always @(negedge clk) begin
    if (reset) begin
      for (int x = 0; x < 2; x++) begin
        mon_hit = (x == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
        mon_err = (x == 0) ? m0_err : m1_err;
        if (mon_hit) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_response: master%0d got ack/err, expected none", x);
          end else begin
            mon_e = exp_q.pop_front();
            check_output("resp_master", x, mon_e.id);
            check_output("resp_err", {31'h0, mon_err}, {31'h0, mon_e.err});
            if (!mon_e.err) check_output("resp_data", m_rdata, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    drive_master(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive_master(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    slave_fixed = 1'b0; slave_lat = 1; slave_data_en = 1'b0; slave_data = 32'h0;
    model_last = 1'b1;

    #3;
    check_output("reset_idle", {30'h0, o_busy, o_owner}, 32'h0);
    m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    check_output("reset_force", {29'h0, s_cyc, s_stb, m0_ack}, 32'h0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    $display("[TB] single master read");
    slave_fixed = 1'b1; slave_lat = 2; slave_data_en = 1'b1; slave_data = 32'hDEADBEEF;
    push_exp(0, 1'b0, 32'hDEADBEEF); model_last = 1'b0;
    fork
      master_txn(0, 32'h100, 1'b0, 32'h0, 4'hF, 1);
      begin
        @(posedge clk); @(negedge clk);
        check_output("grant_addr", s_addr, 32'h100);
        check_output("grant_stb", {30'h0, s_cyc, s_stb}, 32'h3);
        repeat (2) @(negedge clk);
        check_output("ack_latency", {30'h0, m0_ack, m1_ack}, 32'h2);
      end
    join
    slave_data_en = 1'b0;

    $display("[TB] reset during a busy cycle");
    slave_fixed = 1'b1; slave_lat = 1;
    @(posedge clk); #1;
    drive_master(1, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h0, 4'hF);
    @(posedge clk); #1;
    m1_stb = 1'b0;
    #1;
    check_output("pre_reset_ack", {31'h0, m1_ack}, 32'h1);
    #1 reset = 1'b0;
    #1;
    check_output("reset_async", {27'h0, s_cyc, s_stb, m1_ack, m1_err, o_busy}, 32'h0);
    m1_cyc = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_last = 1'b1;

    $display("[TB] tie after reset with strobe replay");
    fork
      apply_stimulus(1'b1, 1'b1, 1, 1);
      begin
        for (int n = 0; n < 60 && !m0_ack; n++) @(negedge clk);
        check_output("tie_m0_first", {31'h0, m0_ack}, 32'h1);
        @(negedge clk);
        check_output("handover_idle", {31'h0, s_cyc}, 32'h0);
        @(negedge clk);
        check_output("replay_stb", {29'h0, s_cyc, s_stb, o_owner}, 32'h7);
      end
    join

    $display("[TB] continuous contention");
    for (int r = 0; r < 4; r++) apply_stimulus(1'b1, 1'b1, 1, 1);

    $display("[TB] timeout on a silent slave");
    slave_fixed = 1'b1; slave_lat = 6;
    push_exp(1, 1'b1, 32'h0); model_last = 1'b1;
    fork
      master_txn(1, 32'h3000, 1'b1, 32'h1234_5678, 4'hF, 4);
      begin
        @(posedge clk); @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
          @(negedge clk);
          check_output("timeout_early", {31'h0, m1_err}, 32'h0);
        end
        @(negedge clk);
        check_output("timeout_err", {31'h0, m1_err}, 32'h1);
        @(negedge clk);
        check_output("drain_state", {30'h0, s_cyc, o_busy}, 32'h1);
        @(negedge clk);
        check_output("late_ack_blocked", {30'h0, m1_ack, m0_ack}, 32'h0);
        repeat (3) @(negedge clk);
        check_output("drain_exit", {31'h0, o_busy}, 32'h0);
      end
    join

    $display("[TB] randomized rounds");
    slave_fixed = 1'b0;
    for (int r = 0; r < 30; r++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      apply_stimulus(pat[0], pat[1], int'($urandom_range(1, 2)), int'($urandom_range(1, 2)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    check_output("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
